// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller in front of a one-cycle-latency single-port memory.
// Define MEM_REQ_CTRL_WRVERIFY_EN to add a read-back check after every write.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
    , VERIFY = 3'd4
`endif
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
      ISSUE:   state_nxt = op_write ? VERIFY : CAPTURE;
      VERIFY:  state_nxt = CAPTURE;
`else
      ISSUE:   state_nxt = op_write ? RESP : CAPTURE;
`endif
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and strobes are gated by reset so nothing is accepted or issued during reset.
  assign req_ready = reset && (state == IDLE);
  assign mem_wr_en = reset && (state == ISSUE) && op_write;
  assign mem_addr  = op_addr;
  assign mem_wdata = op_wdata;

  always_comb begin
    mem_rd_en = reset && (state == ISSUE) && !op_write;
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
    if (reset && (state == VERIFY)) mem_rd_en = 1'b1;
`endif
  end

`ifdef MEM_REQ_CTRL_WRVERIFY_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_write  <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        op_write <= req_write;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
      end
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_write <= op_write;
        rsp_rdata <= op_write ? '0 : mem_rdata;
        err_q     <= op_write && (mem_rdata != op_wdata);
      end
`else
      if (state == ISSUE && op_write) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
      end
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b0;
        rsp_rdata <= mem_rdata;
      end
`endif
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a behavioural one-cycle-latency memory.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_req_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
  localparam int WR_LAT = 3;
  localparam int WR_RD  = 1;
`else
  localparam int WR_LAT = 1;
  localparam int WR_RD  = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stage model plus strobe monitors
  logic [DW-1:0] mem [0:3];
  logic [DW-1:0] mem_q;
  logic          flip = 1'b0;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int n_cmp = 0, n_bad = 0;

  assign mem_rdata = mem_q ^ {{(DW-1){1'b0}}, flip};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end
    if (mem_rd_en === 1'b1) begin
      mem_q  <= mem[mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr_en === 1'b1 && mem_rd_en === 1'b1) both_cnt <= both_cnt + 1;
  end

  // Performs one transaction; lat = rsp_valid rise edge minus accept edge, -1 on timeout.
  task automatic run_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold, output int acc, output int lat,
                        output logic [DW-1:0] rd, output logic rw, output logic er,
                        output int unstable);
    int n;
    acc = -1; lat = -1; rd = 'x; rw = 1'bx; er = 1'bx; unstable = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin req_valid = 1'b0; return; end
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rsp_valid !== 1'b1) return;
    lat = cyc - acc; rd = rsp_rdata; rw = rsp_write; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_write !== rw || rsp_err !== er ||
          req_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) unstable++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'hFF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, mem_wr_en, mem_rd_en, rsp_valid, rsp_write, rsp_err, rsp_rdata,
           mem_addr, mem_wdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got rdy=%b we=%b re=%b rv=%b rw=%b err=%b rd=%h a=%h wd=%h want all 0",
                 i, req_ready, mem_wr_en, mem_rd_en, rsp_valid, rsp_write, rsp_err, rsp_rdata,
                 mem_addr, mem_wdata);
      end
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    int acc, lat, uns, w0, r0;
    logic [DW-1:0] rd; logic rw, er;
    w0 = wr_cnt; r0 = rd_cnt;
    run_op(1'b1, 2'd2, 8'hA5, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (lat !== WR_LAT) begin n_bad++; $display("FAIL wr_latency: got %0d want %0d", lat, WR_LAT); end
    n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL wr_rsp_write: got %b want 1", rw); end
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL wr_rsp_rdata: got %h want 00", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_err: got %b want 0", er); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
    n_cmp++; if (last_wr_addr !== 2'd2 || last_wr_data !== 8'hA5) begin
      n_bad++; $display("FAIL wr_mem_bus: got addr=%0d data=%h want addr=2 data=a5", last_wr_addr, last_wr_data); end
    n_cmp++; if (rd_cnt - r0 !== WR_RD) begin n_bad++; $display("FAIL wr_rd_pulses: got %0d want %0d", rd_cnt - r0, WR_RD); end
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL wr_after_handshake: got rv=%b rdy=%b want rv=0 rdy=1", rsp_valid, req_ready); end
    r0 = rd_cnt;
    run_op(1'b0, 2'd2, 8'hFF, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", rd); end
    n_cmp++; if (rw !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_write: got %b want 0", rw); end
    n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL rd_pulses: got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_backpressure();
    int acc, lat, uns, r0, w0;
    logic [DW-1:0] rd; logic rw, er;
    r0 = rd_cnt; w0 = wr_cnt;
    run_op(1'b0, 2'd2, 8'h00, 5, acc, lat, rd, rw, er, uns);
    n_cmp++; if (rd !== 8'hA5) begin n_bad++; $display("FAIL bp_data: got %h want a5", rd); end
    n_cmp++; if (uns !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", uns); end
    n_cmp++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
      n_bad++; $display("FAIL bp_accesses: got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt - r0, wr_cnt - w0); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got rv=%b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int acc, lat, uns, r0, prev;
    logic [DW-1:0] rd; logic rw, er;
    logic [DW-1:0] exp_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, AW'(i), exp_v[i], 0, acc, lat, rd, rw, er, uns);
      if (i > 0) begin
        n_cmp++; if (acc - prev !== WR_LAT + 2) begin
          n_bad++; $display("FAIL stream_wr_spacing[%0d]: got %0d want %0d", i, acc - prev, WR_LAT + 2); end
      end
      prev = acc;
    end
    r0 = rd_cnt; prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, AW'(i), 8'h00, 0, acc, lat, rd, rw, er, uns);
      n_cmp++; if (rd !== exp_v[i] || lat !== 2) begin
        n_bad++; $display("FAIL stream_rd[%0d]: got data=%h lat=%0d want data=%h lat=2", i, rd, lat, exp_v[i]); end
      if (i > 0) begin
        n_cmp++; if (acc - prev !== 4) begin
          n_bad++; $display("FAIL stream_rd_spacing[%0d]: got %0d want 4", i, acc - prev); end
      end
      prev = acc;
    end
    n_cmp++; if (rd_cnt - r0 !== 4) begin n_bad++; $display("FAIL stream_rd_pulses: got %0d want 4", rd_cnt - r0); end
  endtask

  task automatic test_reset_mid_read();
    int acc, lat, uns, seen;
    logic [DW-1:0] rd; logic rw, er;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, req_ready, mem_rd_en, mem_wr_en, mem_addr} !== '0) begin
      n_bad++; $display("FAIL midrst_in_reset: got rv=%b rdy=%b re=%b we=%b a=%0d want all 0",
                        rsp_valid, req_ready, mem_rd_en, mem_wr_en, mem_addr); end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_response: got %0d bad cycles want 0", seen); end
    run_op(1'b0, 2'd0, 8'h00, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (rd !== 8'h11 || lat !== 2) begin
      n_bad++; $display("FAIL midrst_reread: got data=%h lat=%0d want data=11 lat=2", rd, lat); end
  endtask

  task automatic test_wrverify();
    int acc, lat, uns, r0;
    logic [DW-1:0] rd; logic rw, er;
`ifdef MEM_REQ_CTRL_WRVERIFY_EN
    r0 = rd_cnt;
    flip = 1'b1;
    run_op(1'b1, 2'd3, 8'h5A, 0, acc, lat, rd, rw, er, uns);
    flip = 1'b0;
    n_cmp++; if (er !== 1'b1 || lat !== 3 || rw !== 1'b1) begin
      n_bad++; $display("FAIL verify_forced: got err=%b lat=%0d rw=%b want err=1 lat=3 rw=1", er, lat, rw); end
    n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL verify_rd_pulses: got %0d want 1", rd_cnt - r0); end
    run_op(1'b1, 2'd3, 8'hC3, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (er !== 1'b0 || rd !== 8'h00) begin
      n_bad++; $display("FAIL verify_clean: got err=%b rd=%h want err=0 rd=00", er, rd); end
    run_op(1'b0, 2'd3, 8'h00, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (rd !== 8'hC3) begin n_bad++; $display("FAIL verify_readback: got %h want c3", rd); end
`else
    r0 = rd_cnt;
    flip = 1'b1;
    run_op(1'b1, 2'd3, 8'h5A, 0, acc, lat, rd, rw, er, uns);
    flip = 1'b0;
    n_cmp++; if (er !== 1'b0 || lat !== 1) begin
      n_bad++; $display("FAIL noverify_write: got err=%b lat=%0d want err=0 lat=1", er, lat); end
    n_cmp++; if (rd_cnt - r0 !== 0) begin n_bad++; $display("FAIL noverify_rd_pulses: got %0d want 0", rd_cnt - r0); end
    run_op(1'b0, 2'd3, 8'h00, 0, acc, lat, rd, rw, er, uns);
    n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL noverify_readback: got %h want 5a", rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_wrverify();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL both_strobes: got %0d cycles want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
